// File: rtl/hera_issue_ctrl_pkg.sv
// Shared definitions for the HERA issue controller: state codes,
// default timing parameters and the wait-counter width.
package hera_issue_ctrl_pkg;

  localparam int CNT_W                = 4;
  localparam int MUL_LATENCY_DEF      = 4;
  localparam int REDIRECT_BUBBLES_DEF = 1;
  localparam int RET_HOLD_DEF         = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_RET_HOLD = 3'd4,
    S_REDIRECT = 3'd5
  } state_e;

endpackage

// File: rtl/hera_wait_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module hera_wait_counter
  import hera_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst)                        r_count <= '0;
    else if (load)                   r_count <= load_val;
    else if (dec && r_count != '0)   r_count <= r_count - 1'b1;
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/hera_issue_ctrl.sv
// HERA issue sequencer: stalls fetch/writeback across memory and multiply
// operations and inserts kill bubbles after control transfers.
module hera_issue_ctrl
  import hera_issue_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY      = MUL_LATENCY_DEF,
  parameter int REDIRECT_BUBBLES = REDIRECT_BUBBLES_DEF,
  parameter int RET_HOLD         = RET_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       instr_valid,
  input  logic       load_en,
  input  logic       mem_en,
  input  logic       mul_en,
  input  logic       call_en,
  input  logic       return_en,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_load,
  output logic       ir_en,
  output logic       rf_we,
  output logic       mem_req,
  output logic       mul_start,
  output logic       kill,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LATENCY - 2);
  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(REDIRECT_BUBBLES - 1);
  localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_HOLD - 1);

  // Plain vector rather than state_e so codes 6-7 are representable and recoverable.
  logic [2:0]       r_state;
  logic [2:0]       w_nxt_state;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;

  hera_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_dec   = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    ir_en       = 1'b0;
    rf_we       = 1'b0;
    mem_req     = 1'b0;
    mul_start   = 1'b0;
    kill        = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_nxt_state = S_RUN;
      S_RUN: begin
        if (!instr_valid) begin
          if (!run) w_nxt_state = S_IDLE;
        end else if (return_en) begin
          w_nxt_state = S_RET_HOLD;
          w_cnt_load  = 1'b1;
          w_cnt_val   = RET_LD;
        end else if (call_en || branch_taken) begin
          pc_en       = 1'b1;
          pc_load     = 1'b1;
          rf_we       = call_en;  // call writes the link register
          w_nxt_state = S_REDIRECT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = RED_LD;
        end else if (mem_en) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            pc_en = 1'b1;
            ir_en = 1'b1;
            rf_we = load_en;
            if (!run) w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_MEM_WAIT;
          end
        end else if (mul_en) begin
          mul_start   = 1'b1;
          w_nxt_state = S_MUL_WAIT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = MUL_LD;
        end else begin
          pc_en = 1'b1;
          ir_en = 1'b1;
          rf_we = 1'b1;
          if (!run) w_nxt_state = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          pc_en       = 1'b1;
          ir_en       = 1'b1;
          rf_we       = load_en;
          w_nxt_state = run ? S_RUN : S_IDLE;
        end
      end
      S_MUL_WAIT: begin
        if (w_cnt_zero) begin
          pc_en       = 1'b1;
          ir_en       = 1'b1;
          rf_we       = 1'b1;
          w_nxt_state = S_RUN;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_RET_HOLD: begin
        if (w_cnt_zero) begin
          pc_en       = 1'b1;
          pc_load     = 1'b1;
          w_nxt_state = S_REDIRECT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = RED_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_REDIRECT: begin
        kill  = 1'b1;
        pc_en = 1'b1;
        ir_en = 1'b1;
        if (w_cnt_zero) w_nxt_state = S_RUN;
        else            w_cnt_dec   = 1'b1;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign state = r_state;

endmodule

// File: tb/tb_hera_issue_ctrl.sv
// Directed bench for hera_issue_ctrl with MUL_LATENCY=4, REDIRECT_BUBBLES=2, RET_HOLD=1.
module tb_hera_issue_ctrl;
  import hera_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, run, instr_valid, load_en, mem_en, mul_en, call_en, return_en, branch_taken, mem_ready;
  logic pc_en, pc_load, ir_en, rf_we, mem_req, mul_start, kill, busy;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hera_issue_ctrl #(.MUL_LATENCY(4), .REDIRECT_BUBBLES(2), .RET_HOLD(1)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_valid(instr_valid), .load_en(load_en),
    .mem_en(mem_en), .mul_en(mul_en), .call_en(call_en), .return_en(return_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .pc_en(pc_en), .pc_load(pc_load),
    .ir_en(ir_en), .rf_we(rf_we), .mem_req(mem_req), .mul_start(mul_start), .kill(kill),
    .busy(busy), .state(state)
  );

  // output bundle order: pc_en pc_load ir_en rf_we mem_req mul_start kill
  localparam logic [6:0] O_NONE   = 7'b000_0000;
  localparam logic [6:0] O_SIMPLE = 7'b101_1000;
  localparam logic [6:0] O_MREQ   = 7'b000_0100;
  localparam logic [6:0] O_LDDONE = 7'b101_1100;
  localparam logic [6:0] O_STDONE = 7'b101_0100;
  localparam logic [6:0] O_MULST  = 7'b000_0010;
  localparam logic [6:0] O_BRANCH = 7'b110_0000;
  localparam logic [6:0] O_CALL   = 7'b110_1000;
  localparam logic [6:0] O_KILL   = 7'b101_0001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic dec(input logic v, input logic ld, input logic me, input logic mu,
                     input logic ca, input logic re, input logic br, input logic rdy);
    instr_valid = v; load_en = ld; mem_en = me; mul_en = mu;
    call_en = ca; return_en = re; branch_taken = br; mem_ready = rdy;
  endtask

  // Called at posedge+1 with inputs applied; samples, then advances one cycle.
  task automatic cyc(input string tag, input logic [2:0] exp_st, input logic [6:0] exp_o);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(exp_st));
    chk({tag, ".outs"}, 32'({pc_en, pc_load, ir_en, rf_we, mem_req, mul_start, kill}), 32'(exp_o));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_st != S_IDLE));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc("reset", S_IDLE, O_NONE);

    rst = 1'b1; run = 1'b1;
    cyc("idle_go", S_IDLE, O_NONE);
    dec(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("simple%0d", i), S_RUN, O_SIMPLE);

    dec(1, 1, 1, 0, 0, 0, 0, 0);
    cyc("ld_c0", S_RUN, O_MREQ);
    cyc("ld_c1", S_MEM_WAIT, O_MREQ);
    cyc("ld_c2", S_MEM_WAIT, O_MREQ);
    mem_ready = 1'b1;
    cyc("ld_c3", S_MEM_WAIT, O_LDDONE);

    dec(1, 0, 1, 0, 0, 0, 0, 0);
    cyc("st_c0", S_RUN, O_MREQ);
    cyc("st_c1", S_MEM_WAIT, O_MREQ);
    cyc("st_c2", S_MEM_WAIT, O_MREQ);
    mem_ready = 1'b1;
    cyc("st_c3", S_MEM_WAIT, O_STDONE);

    dec(1, 0, 0, 1, 0, 0, 0, 1);  // mem_ready must be ignored outside MEM_WAIT
    cyc("mul_c0", S_RUN, O_MULST);
    cyc("mul_c1", S_MUL_WAIT, O_NONE);
    cyc("mul_c2", S_MUL_WAIT, O_NONE);
    cyc("mul_c3", S_MUL_WAIT, O_SIMPLE);

    dec(1, 0, 0, 0, 0, 0, 1, 0);
    cyc("br_c0", S_RUN, O_BRANCH);
    cyc("br_c1", S_REDIRECT, O_KILL);
    cyc("br_c2", S_REDIRECT, O_KILL);
    dec(1, 0, 0, 0, 1, 0, 0, 0);
    cyc("call_c0", S_RUN, O_CALL);
    cyc("call_c1", S_REDIRECT, O_KILL);
    cyc("call_c2", S_REDIRECT, O_KILL);

    dec(1, 0, 0, 0, 0, 1, 0, 0);
    cyc("ret_c0", S_RUN, O_NONE);
    cyc("ret_c1", S_RET_HOLD, O_BRANCH);
    cyc("ret_c2", S_REDIRECT, O_KILL);
    cyc("ret_c3", S_REDIRECT, O_KILL);
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ret_c4", S_RUN, O_NONE);

    dec(1, 1, 1, 0, 0, 0, 0, 0);
    cyc("rst_c0", S_RUN, O_MREQ);
    cyc("rst_c1", S_MEM_WAIT, O_MREQ);
    rst = 1'b0;
    cyc("rst_c2", S_MEM_WAIT, O_MREQ);
    cyc("rst_c3", S_IDLE, O_NONE);
    rst = 1'b1;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst_c4", S_IDLE, O_NONE);

    dec(1, 0, 0, 1, 0, 0, 0, 0);
    cyc("stop_c0", S_RUN, O_MULST);
    run = 1'b0;
    cyc("stop_c1", S_MUL_WAIT, O_NONE);
    cyc("stop_c2", S_MUL_WAIT, O_NONE);
    cyc("stop_c3", S_MUL_WAIT, O_SIMPLE);
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("stop_c4", S_RUN, O_NONE);
    cyc("stop_c5", S_IDLE, O_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
